mfp_ahb_timer: RTL and testbench

MFP_AHB_TIMER -- requirements
Module: mfp_ahb_timer

---
 rtl/mfp_ahb_timer_pkg.sv | 34 +++
 rtl/mfp_timer_prescaler.sv | 24 ++
 rtl/mfp_ahb_timer.sv | 126 ++++++++++++
 tb/tb_mfp_ahb_timer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mfp_ahb_timer_pkg.sv
// Shared constants and types for the AHB-lite timer: register offsets, bit
// positions, decoder match value and the captured address-phase record.
package mfp_ahb_timer_pkg;

  localparam logic [3:0]  TMR_CTRL_OFF    = 4'h0;
  localparam logic [3:0]  TMR_COUNT_OFF   = 4'h4;
  localparam logic [3:0]  TMR_COMPARE_OFF = 4'h8;
  localparam logic [3:0]  TMR_STATUS_OFF  = 4'hC;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_AR_BIT      = 1;
  localparam int CTRL_IE_BIT      = 2;
  localparam int CTRL_PRESC_LSB   = 8;
  localparam int STATUS_MATCH_BIT = 0;

  // Upper address bits the system decoder compares to select this slave.
  localparam logic [19:0] H_TMR_ADDR_Match = 20'h1f804;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    REG_CTRL    = TMR_CTRL_OFF[3:2],
    REG_COUNT   = TMR_COUNT_OFF[3:2],
    REG_COMPARE = TMR_COMPARE_OFF[3:2],
    REG_STATUS  = TMR_STATUS_OFF[3:2]
  } reg_sel_e;

  typedef struct packed {
    logic     vld;
    logic     write;
    reg_sel_e sel;
  } ap_t;

endpackage

// File: rtl/mfp_timer_prescaler.sv
// Free-running prescaler: one-cycle tick each time the counter reaches presc.
// clr restarts the count and suppresses that cycle's tick.
module mfp_timer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clr,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt;

  assign tick = en & ~clr & (cnt == presc);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                   cnt <= '0;
    else if (!en || clr || tick) cnt <= '0;
    else                         cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/mfp_ahb_timer.sv
// AHB-lite timer slave: address-phase capture, CTRL/COUNT/COMPARE/STATUS
// register file, count/match logic and registered level interrupt.
module mfp_ahb_timer
  import mfp_ahb_timer_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [3:0]  HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic        HSEL,
  output logic [31:0] HRDATA,
  output logic        TMR_IRQ
);

  ap_t                ap;
  logic               en, ar, ie, match;
  logic [PRESC_W-1:0] presc;
  logic [31:0]        count, compare;

  logic               en_nxt, ar_nxt, ie_nxt, match_nxt, match_set;
  logic [PRESC_W-1:0] presc_nxt;
  logic [31:0]        count_nxt, compare_nxt, rd_nxt;
  logic               we_ctrl, we_count, we_compare, we_status;
  logic               accept, tick;
  logic               unused_bits;

  assign unused_bits = ^{HADDR[1:0], HTRANS[0]};
  assign accept      = HSEL & HTRANS[1];

  assign we_ctrl    = ap.vld & ap.write & (ap.sel == REG_CTRL);
  assign we_count   = ap.vld & ap.write & (ap.sel == REG_COUNT);
  assign we_compare = ap.vld & ap.write & (ap.sel == REG_COMPARE);
  assign we_status  = ap.vld & ap.write & (ap.sel == REG_STATUS);

  // Any CTRL write restarts the prescaler; with EN written low this also
  // kills the tick that would otherwise land on the write edge.
  mfp_timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk  (HCLK),
    .rstn (HRESETn),
    .en   (en),
    .presc(presc),
    .clr  (we_ctrl),
    .tick (tick)
  );

  always_comb begin
    en_nxt    = en;
    ar_nxt    = ar;
    ie_nxt    = ie;
    presc_nxt = presc;
    if (we_ctrl) begin
      en_nxt    = HWDATA[CTRL_EN_BIT];
      ar_nxt    = HWDATA[CTRL_AR_BIT];
      ie_nxt    = HWDATA[CTRL_IE_BIT];
      presc_nxt = HWDATA[CTRL_PRESC_LSB +: PRESC_W];
    end
  end

  // Software COUNT writes win over the tick and skip match evaluation.
  always_comb begin
    count_nxt = count;
    match_set = 1'b0;
    if (we_count) begin
      count_nxt = HWDATA;
    end else if (tick) begin
      if (count == compare) begin
        match_set = 1'b1;
        count_nxt = ar ? 32'd0 : count + 32'd1;
      end else begin
        count_nxt = count + 32'd1;
      end
    end
  end

  assign compare_nxt = we_compare ? HWDATA : compare;
  assign match_nxt   = match_set | (match & ~(we_status & HWDATA[STATUS_MATCH_BIT]));

  // Reads sample post-edge register values, which forwards a write whose
  // data phase coincides with this read's address phase.
  always_comb begin
    rd_nxt = '0;
    case (reg_sel_e'(HADDR[3:2]))
      REG_CTRL: begin
        rd_nxt[CTRL_EN_BIT]                = en_nxt;
        rd_nxt[CTRL_AR_BIT]                = ar_nxt;
        rd_nxt[CTRL_IE_BIT]                = ie_nxt;
        rd_nxt[CTRL_PRESC_LSB +: PRESC_W]  = presc_nxt;
      end
      REG_COUNT:   rd_nxt = count_nxt;
      REG_COMPARE: rd_nxt = compare_nxt;
      REG_STATUS:  rd_nxt[STATUS_MATCH_BIT] = match_nxt;
      default:     rd_nxt = '0;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap      <= '{vld: 1'b0, write: 1'b0, sel: REG_CTRL};
      en      <= 1'b0;
      ar      <= 1'b0;
      ie      <= 1'b0;
      presc   <= '0;
      count   <= '0;
      compare <= COMPARE_RST;
      match   <= 1'b0;
      HRDATA  <= '0;
      TMR_IRQ <= 1'b0;
    end else begin
      ap      <= '{vld: accept, write: HWRITE, sel: reg_sel_e'(HADDR[3:2])};
      en      <= en_nxt;
      ar      <= ar_nxt;
      ie      <= ie_nxt;
      presc   <= presc_nxt;
      count   <= count_nxt;
      compare <= compare_nxt;
      match   <= match_nxt;
      if (accept && !HWRITE) HRDATA <= rd_nxt;
      TMR_IRQ <= match & ie;
    end
  end

endmodule

// File: tb/tb_mfp_ahb_timer.sv
// Bench for mfp_ahb_timer: register-access vector table plus hand sequences
// for auto-reload, prescaler wrap, collisions and mid-operation reset.
module tb_mfp_ahb_timer;

  logic        HCLK, HRESETn, HWRITE, HSEL, TMR_IRQ;
  logic [3:0]  HADDR;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA, HRDATA;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[14];

  mfp_ahb_timer #(.PRESC_W(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWDATA(HWDATA), .HWRITE(HWRITE), .HSEL(HSEL), .HRDATA(HRDATA),
    .TMR_IRQ(TMR_IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive an address phase, then after the edge drive this
  // transfer's write data and retire any read expected this cycle.
  task automatic xfer(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [3:0] addr, input logic [31:0] wdata,
                      input logic chk, input logic [31:0] exp, input string name);
    sb_t e;
    HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = addr;
    if (sel && trans[1] && !wr && chk) begin
      e.exp = exp; e.name = name;
      sb.push_back(e);
    end
    @(posedge HCLK); #1;
    HWDATA = wdata;
    HSEL = 1'b0; HTRANS = 2'b00;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, HRDATA, e.exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    xfer(1'b1, 2'b10, 1'b1, a, d, 1'b0, 32'd0, "");
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
    xfer(1'b1, 2'b10, 1'b0, a, 32'd0, 1'b1, exp, name);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) xfer(1'b0, 2'b00, 1'b0, 4'h0, 32'd0, 1'b0, 32'd0, "");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b0, 4'h0, 32'd0,         32'h0000_0000};
    vt[1]  = '{1'b0, 4'h4, 32'd0,         32'h0000_0000};
    vt[2]  = '{1'b0, 4'h8, 32'd0,         32'hFFFF_FFFF};
    vt[3]  = '{1'b0, 4'hC, 32'd0,         32'h0000_0000};
    vt[4]  = '{1'b1, 4'h8, 32'h0000_0010, 32'd0};
    vt[5]  = '{1'b0, 4'h8, 32'd0,         32'h0000_0010};
    vt[6]  = '{1'b1, 4'h0, 32'hFFFF_FFF8, 32'd0};
    vt[7]  = '{1'b0, 4'h0, 32'd0,         32'h0000_FF00};
    vt[8]  = '{1'b1, 4'h4, 32'h1234_5678, 32'd0};
    vt[9]  = '{1'b0, 4'h4, 32'd0,         32'h1234_5678};
    vt[10] = '{1'b1, 4'h0, 32'h0000_0000, 32'd0};
    vt[11] = '{1'b0, 4'h0, 32'd0,         32'h0000_0000};
    vt[12] = '{1'b1, 4'h4, 32'h0000_0000, 32'd0};
    vt[13] = '{1'b0, 4'hC, 32'd0,         32'h0000_0000};

    HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    HADDR = 4'h0; HWDATA = 32'd0;
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_irq", {31'd0, TMR_IRQ}, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    for (int i = 0; i < 14; i++) begin
      if (vt[i].wr) wr(vt[i].addr, vt[i].data);
      else          rd(vt[i].addr, vt[i].exp, $sformatf("vec%0d", i));
    end

    // Auto-reload with PRESC=0: match on the 6th tick, IRQ one cycle later.
    wr(4'h8, 32'd5);
    wr(4'h4, 32'd0);
    wr(4'h0, 32'h7);
    idle(5);
    rd(4'h4, 32'd5, "ar_count5");
    rd(4'h4, 32'd0, "ar_reload");
    check("ar_irq_lag", {31'd0, TMR_IRQ}, 32'd0);
    rd(4'hC, 32'd1, "ar_match");
    check("ar_irq_set", {31'd0, TMR_IRQ}, 32'd1);
    wr(4'hC, 32'd1);
    rd(4'hC, 32'd0, "ar_w1c");
    check("ar_irq_hold", {31'd0, TMR_IRQ}, 32'd1);
    idle(1);
    check("ar_irq_clr", {31'd0, TMR_IRQ}, 32'd0);
    wr(4'h0, 32'h0);
    rd(4'h4, 32'd5, "en0_freeze");
    rd(4'hC, 32'd0, "en0_nomatch");

    // PRESC=3 and 32-bit wrap.
    wr(4'h4, 32'hFFFF_FFFE);
    wr(4'h0, 32'h0000_0301);
    rd(4'h4, 32'hFFFF_FFFE, "ps_start");
    idle(2);
    rd(4'h4, 32'hFFFF_FFFE, "ps_cyc3");
    rd(4'h4, 32'hFFFF_FFFF, "ps_cyc4");
    idle(2);
    rd(4'h4, 32'hFFFF_FFFF, "ps_cyc7");
    rd(4'h4, 32'h0000_0000, "ps_wrap");
    wr(4'h0, 32'h0);
    idle(1);

    // COUNT write against a matching tick, then W1C against a match set.
    wr(4'h8, 32'd0);
    wr(4'h4, 32'd0);
    wr(4'h0, 32'h1);
    wr(4'h4, 32'h100);
    rd(4'h4, 32'h100, "col_cnt_wr");
    rd(4'hC, 32'd0, "col_no_match");
    wr(4'h8, 32'h106);
    idle(3);
    wr(4'hC, 32'd1);
    rd(4'hC, 32'd1, "col_set_wins");
    wr(4'h0, 32'h0);
    wr(4'hC, 32'd1);
    idle(1);
    rd(4'hC, 32'd0, "col_cleared");

    // Reset in the data phase of a COUNT write while the counter runs.
    wr(4'h8, 32'h55);
    wr(4'h0, 32'h1);
    idle(3);
    rd(4'h8, 32'h55, "pre_rst_cmp");
    wr(4'h4, 32'hABCD);
    HRESETn = 1'b0;
    #1;
    check("rst_async_hrdata", HRDATA, 32'd0);
    check("rst_async_irq", {31'd0, TMR_IRQ}, 32'd0);
    @(posedge HCLK); #2;
    HRESETn = 1'b1;
    rd(4'h0, 32'd0, "post_rst_ctrl");
    rd(4'h4, 32'd0, "post_rst_count");
    rd(4'h8, 32'hFFFF_FFFF, "post_rst_cmp");
    rd(4'hC, 32'd0, "post_rst_status");

    // Unselected or idle transfers must not write.
    xfer(1'b0, 2'b10, 1'b1, 4'h8, 32'h77, 1'b0, 32'd0, "");
    idle(1);
    xfer(1'b1, 2'b00, 1'b1, 4'h8, 32'h88, 1'b0, 32'd0, "");
    idle(1);
    rd(4'h8, 32'hFFFF_FFFF, "hsel0_nowrite");

    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
